sprite_linebuf: RTL and testbench
=================================

# sprite_linebuf

Double-buffered sprite line buffer between the sprite renderer and the composer. During a scanline the render bank takes read-modify-write traffic from the renderer while the display bank is read out by the composer. Every display read clears the entry it reads, so the bank is already empty when it becomes the render bank again. After reset, an init sweep zeroes both banks before the block accepts any traffic.

## Interface
Parameters:
- none (depth fixed at 640 visible entries × 16 bits per bank)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- line_render_start  in  1  swap pulse: render bank becomes display bank and vice versa
- ready  out  1  high once the init sweep has completed
- render_bank  out  1  index of the bank currently in the render role
- rend_rdidx  in  10  renderer read address
- rend_rddata  out  16  renderer read data, registered
- rend_wridx  in  10  renderer write address
- rend_wrdata  in  16  renderer write data {collision[3:0], 2'b0, z[1:0], color[7:0]}
- rend_wren  in  1  renderer write enable
- disp_rdidx  in  10  composer read address
- disp_rden  in  1  composer read strobe; the entry read is cleared
- disp_rddata  out  16  composer read data
- disp_valid  out  1  disp_rddata holds the result of a strobed read

## Operation
- Storage:
  - two banks, 640×16 each, true dual-port synchronous RAM.
  - Contents are not reset; the init sweep zeroes them.
- FSM states:
  - INIT: after rst_n low, a 10-bit counter writes 0 to address 0..639 of both banks, one address per cycle, for 640 cycles. During INIT:
    - ready=0
    - renderer writes and display reads are ignored
    - rend_rddata, disp_rddata and disp_valid stay 0
    - line_render_start is ignored
    - After address 639 is written, go to RUN.
  - RUN: ready=1. Stays in RUN until rst_n is asserted.
- Bank roles:
  - render_bank resets to 0.
  - line_render_start in RUN toggles render_bank at the next edge.
  - All requests in the swap cycle use the pre-swap roles.
- Renderer port (render bank only):
  - Read of rend_rdidx returns data next cycle.
  - Write commits at the edge when rend_wren=1.
  - Same-cycle write and read to the same index: rend_rddata returns rend_wrdata (write-first bypass).
  - Index ≥640: writes are dropped; reads return 0.
- Display port (display bank only):
  - disp_rden with disp_rdidx<640: read the entry, then write 0 to the same address of the same bank one cycle later. The clear write uses the registered bank select, so a clear issued around a swap still lands in the old display bank.
  - Index ≥640: returns 0, disp_valid=1, no clear.
  - The composer reads each index 0..639 exactly once per line. That is the contract that keeps the banks clean.
- Renderer and composer never touch the same bank in the same cycle, so no cross-port arbitration is needed.

## Timing
- Reset values: ready=0, render_bank=0, rend_rddata=0, disp_rddata=0, disp_valid=0, FSM=INIT, sweep counter=0.
- Init takes 640 cycles. ready rises on the cycle after the address-639 write.
- Renderer read latency is 1 cycle. Write-to-read turnaround at the same address is 0 cycles (bypass).
- Display read latency is 1 cycle (2 with the output register). disp_valid is a 1-cycle pulse per strobe; disp_rddata holds its value between strobes.
- Back-to-back display reads every cycle are supported. The clear for read N and the read N+1 go to different addresses through separate ports.
- Reset mid-operation: the next edge enters INIT. Pending clears and outputs are discarded, and the sweep restarts from 0.

## Configuration
- SPRITE_LINEBUF_OUTREG_EN defined:
  - adds a register stage on disp_rddata/disp_valid; display latency is 2 cycles
  - the clear write still occurs 1 cycle after the strobe
- Undefined: display latency is 1 cycle; RAM output drives disp_rddata directly.
- The renderer port is unaffected either way.

## Test plan
- Reset, then hold rst_n=1 → ready=0 for exactly 640 cycles, then 1. Every display read of 0..639 on both banks returns 0x0000.
- RUN, write rend_wridx=5, wrdata=0x1234, with read rend_rdidx=5 in the same cycle → rend_rddata=0x1234 next cycle. Read idx 5 again later → 0x1234.
- Write idx 700, data 0xFFFF, then read idx 700 → 0x0000. No entry 0..639 is modified.
- Write idx 10=0xA0C3, pulse line_render_start, then disp_rden idx 10 → disp_rddata=0xA0C3, disp_valid=1 after 1 cycle. Read idx 10 again → 0x0000.
- Assert disp_rden on idx 10 in the same cycle as line_render_start → data comes from the old display bank, that bank's entry is cleared, and the new display bank is untouched.
- With SPRITE_LINEBUF_OUTREG_EN, the read in the previous case → disp_valid appears 2 cycles after the strobe.
- Assert rst_n low mid-line with dirty entries → INIT reruns and all entries read 0x0000 afterwards.

Source files
------------

// File: rtl/sprite_linebuf.sv
// Double-buffered 640x16 sprite line buffer: renderer RMW on one bank, composer read-and-clear on the other.
// Latency: renderer read 1 cycle (write-first bypass); display read 1 cycle, 2 with SPRITE_LINEBUF_OUTREG_EN.
// Backpressure: none; traffic is ignored until the post-reset init sweep finishes (ready=1).
module sprite_linebuf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_render_start,
    output logic        ready,
    output logic        render_bank,
    input  logic [9:0]  rend_rdidx,
    output logic [15:0] rend_rddata,
    input  logic [9:0]  rend_wridx,
    input  logic [15:0] rend_wrdata,
    input  logic        rend_wren,
    input  logic [9:0]  disp_rdidx,
    input  logic        disp_rden,
    output logic [15:0] disp_rddata,
    output logic        disp_valid
);

    localparam int unsigned DEPTH    = 640;
    localparam logic [9:0]  DEPTH_IX = 10'd640;
    localparam logic [9:0]  LAST_IX  = 10'd639;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic [9:0]  sweep_q, sweep_d;
    logic        render_bank_q, render_bank_d;
    logic [15:0] rend_rddata_q, rend_rddata_d;
    logic [15:0] disp_rddata_q, disp_rddata_d;
    logic        disp_valid_q, disp_valid_d;
    logic        clr_vld_q, clr_vld_d;
    logic [9:0]  clr_idx_q, clr_idx_d;
    logic        clr_bank_q, clr_bank_d;

    logic [15:0] mem0 [DEPTH];
    logic [15:0] mem1 [DEPTH];

    logic        run;
    logic        disp_bank;
    logic        rend_rd_ok, rend_wr_ok, disp_rd_ok;
    logic [15:0] rend_mem_dat, disp_mem_dat;
    logic        a_we0, a_we1;
    logic [9:0]  a_addr;
    logic [15:0] a_dat;
    logic        b_we0, b_we1;

    assign run          = (state_q == ST_RUN);
    assign disp_bank    = ~render_bank_q;
    assign rend_rd_ok   = (rend_rdidx < DEPTH_IX);
    assign rend_wr_ok   = (rend_wridx < DEPTH_IX);
    assign disp_rd_ok   = (disp_rdidx < DEPTH_IX);
    assign rend_mem_dat = render_bank_q ? mem1[rend_rdidx] : mem0[rend_rdidx];
    assign disp_mem_dat = disp_bank     ? mem1[disp_rdidx] : mem0[disp_rdidx];

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + 10'd1;
                if (sweep_q == LAST_IX) begin
                    state_d = ST_RUN;
                    sweep_d = '0;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Port A carries the init sweep, then renderer writes; port B carries display clears.
    always_comb begin
        a_we0  = 1'b0;
        a_we1  = 1'b0;
        a_addr = rend_wridx;
        a_dat  = rend_wrdata;
        if (!run) begin
            a_we0  = 1'b1;
            a_we1  = 1'b1;
            a_addr = sweep_q;
            a_dat  = '0;
        end else if (rend_wren && rend_wr_ok) begin
            a_we0 = ~render_bank_q;
            a_we1 = render_bank_q;
        end
        b_we0 = clr_vld_q & ~clr_bank_q;
        b_we1 = clr_vld_q & clr_bank_q;
    end

    always_comb begin
        render_bank_d = render_bank_q;
        if (run && line_render_start) begin
            render_bank_d = ~render_bank_q;
        end

        // A clear still in flight looks already done to the renderer after a swap.
        rend_rddata_d = '0;
        if (run && rend_rd_ok) begin
            if (rend_wren && rend_wridx == rend_rdidx) begin
                rend_rddata_d = rend_wrdata;
            end else if (clr_vld_q && clr_bank_q == render_bank_q && clr_idx_q == rend_rdidx) begin
                rend_rddata_d = '0;
            end else begin
                rend_rddata_d = rend_mem_dat;
            end
        end

        disp_valid_d  = run & disp_rden;
        disp_rddata_d = run ? disp_rddata_q : '0;
        clr_vld_d     = 1'b0;
        clr_idx_d     = disp_rdidx;
        clr_bank_d    = disp_bank;
        if (run && disp_rden) begin
            disp_rddata_d = disp_rd_ok ? disp_mem_dat : '0;
            clr_vld_d     = disp_rd_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            sweep_q       <= '0;
            render_bank_q <= 1'b0;
            rend_rddata_q <= '0;
            disp_rddata_q <= '0;
            disp_valid_q  <= 1'b0;
            clr_vld_q     <= 1'b0;
            clr_idx_q     <= '0;
            clr_bank_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sweep_q       <= sweep_d;
            render_bank_q <= render_bank_d;
            rend_rddata_q <= rend_rddata_d;
            disp_rddata_q <= disp_rddata_d;
            disp_valid_q  <= disp_valid_d;
            clr_vld_q     <= clr_vld_d;
            clr_idx_q     <= clr_idx_d;
            clr_bank_q    <= clr_bank_d;
        end
    end

    // Renderer write is ordered after the clear so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (b_we0) mem0[clr_idx_q] <= '0;
        if (a_we0) mem0[a_addr]    <= a_dat;
        if (b_we1) mem1[clr_idx_q] <= '0;
        if (a_we1) mem1[a_addr]    <= a_dat;
    end

`ifdef SPRITE_LINEBUF_OUTREG_EN
    logic [15:0] disp_out_q, disp_out_d;
    logic        disp_out_vld_q, disp_out_vld_d;

    always_comb begin
        disp_out_vld_d = run & disp_valid_q;
        disp_out_d     = '0;
        if (run) begin
            disp_out_d = disp_valid_q ? disp_rddata_q : disp_out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_out_q     <= '0;
            disp_out_vld_q <= 1'b0;
        end else begin
            disp_out_q     <= disp_out_d;
            disp_out_vld_q <= disp_out_vld_d;
        end
    end

    assign disp_rddata = disp_out_q;
    assign disp_valid  = disp_out_vld_q;
`else
    assign disp_rddata = disp_rddata_q;
    assign disp_valid  = disp_valid_q;
`endif

    assign ready       = run;
    assign render_bank = render_bank_q;
    assign rend_rddata = rend_rddata_q;

endmodule

// File: tb/tb_sprite_linebuf.sv
// Bench for sprite_linebuf: directed scenarios plus randomized traffic against an array model.
module tb_sprite_linebuf;

`ifdef SPRITE_LINEBUF_OUTREG_EN
    localparam int DLAT = 2;
`else
    localparam int DLAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        line_render_start;
    logic        ready;
    logic        render_bank;
    logic [9:0]  rend_rdidx;
    logic [15:0] rend_rddata;
    logic [9:0]  rend_wridx;
    logic [15:0] rend_wrdata;
    logic        rend_wren;
    logic [9:0]  disp_rdidx;
    logic        disp_rden;
    logic [15:0] disp_rddata;
    logic        disp_valid;

    int checks   = 0;
    int failures = 0;

    // Model: bank contents, render-bank index, display output pipeline.
    logic [15:0] m [2][640];
    int          mrb;
    logic [15:0] exp_rend, exp_dd, d1, d2;
    logic        exp_dv, v1, v2;

    always #5 clk = ~clk;

    sprite_linebuf dut (
        .clk(clk), .rst_n(rst_n), .line_render_start(line_render_start),
        .ready(ready), .render_bank(render_bank),
        .rend_rdidx(rend_rdidx), .rend_rddata(rend_rddata),
        .rend_wridx(rend_wridx), .rend_wrdata(rend_wrdata), .rend_wren(rend_wren),
        .disp_rdidx(disp_rdidx), .disp_rden(disp_rden),
        .disp_rddata(disp_rddata), .disp_valid(disp_valid)
    );

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 640; i++) m[b][i] = 16'h0;
        mrb = 0;
        exp_rend = 16'h0; exp_dd = 16'h0; d1 = 16'h0; d2 = 16'h0;
        exp_dv = 1'b0; v1 = 1'b0; v2 = 1'b0;
    endtask

    task automatic drive_idle();
        line_render_start = 1'b0; rend_wren = 1'b0; rend_wridx = 10'd0; rend_wrdata = 16'h0;
        rend_rdidx = 10'd0; disp_rden = 1'b0; disp_rdidx = 10'd0;
    endtask

    // Drives one RUN cycle, advances the model, and sets exp_* for the outputs after the edge.
    task automatic tick(input logic swap, input logic wren, input logic [9:0] wridx,
                        input logic [15:0] wrdata, input logic [9:0] rdidx,
                        input logic rden, input logic [9:0] didx);
        logic [15:0] dv;
        int rb, db;
        line_render_start = swap; rend_wren = wren; rend_wridx = wridx; rend_wrdata = wrdata;
        rend_rdidx = rdidx; disp_rden = rden; disp_rdidx = didx;
        rb = mrb; db = 1 - mrb;
        if (wren && wridx < 10'd640) m[rb][wridx] = wrdata;
        exp_rend = (rdidx < 10'd640) ? m[rb][rdidx] : 16'h0;
        dv = 16'h0;
        if (rden && didx < 10'd640) begin
            dv = m[db][didx];
            m[db][didx] = 16'h0;
        end
        if (swap) mrb = 1 - mrb;
        if (v1) d2 = d1;
        v2 = v1;
        if (rden) d1 = dv;
        v1 = rden;
        exp_dv = (DLAT == 1) ? v1 : v2;
        exp_dd = (DLAT == 1) ? d1 : d2;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int n;
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (render_bank !== 1'b0) begin failures++; $display("FAIL reset_bank got=%b exp=0", render_bank); end
        checks++; if (rend_rddata !== 16'h0) begin failures++; $display("FAIL reset_rend got=%h exp=0000", rend_rddata); end
        checks++; if (disp_rddata !== 16'h0) begin failures++; $display("FAIL reset_disp got=%h exp=0000", disp_rddata); end
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", disp_valid); end
        rst_n = 1'b1;
        n = 0;
        // Traffic during INIT must be ignored entirely.
        while (n < 2000) begin
            rend_wren = 1'b1; rend_wridx = 10'($urandom_range(0, 639)); rend_wrdata = 16'($urandom);
            rend_rdidx = rend_wridx; disp_rden = 1'b1; disp_rdidx = 10'($urandom_range(0, 639));
            line_render_start = 1'($urandom);
            @(posedge clk); #1;
            n++;
            if (ready) break;
            checks++;
            if (rend_rddata !== 16'h0 || disp_rddata !== 16'h0 || disp_valid !== 1'b0 || render_bank !== 1'b0) begin
                failures++;
                $display("FAIL init_quiet cycle=%0d got rend=%h disp=%h vld=%b bank=%b exp all 0",
                         n, rend_rddata, disp_rddata, disp_valid, render_bank);
            end
        end
        drive_idle();
        checks++; if (n !== 640) begin failures++; $display("FAIL init_len got=%0d exp=640", n); end
        model_reset();
    endtask

    task automatic test_all_zero();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 640; i++) begin
                tick(1'b0, 1'b0, 10'd0, 16'h0, 10'(i), 1'b1, 10'(i));
                checks++;
                if (disp_valid !== exp_dv || disp_rddata !== exp_dd || rend_rddata !== exp_rend) begin
                    failures++;
                    $display("FAIL zero_scan idx=%0d got d=%h v=%b r=%h exp d=%h v=%b r=%h",
                             i, disp_rddata, disp_valid, rend_rddata, exp_dd, exp_dv, exp_rend);
                end
            end
            tick(1'b1, 1'b0, 10'd0, 16'h0, 10'd0, 1'b0, 10'd0);
            checks++;
            if (disp_valid !== exp_dv || disp_rddata !== 16'h0 || render_bank !== 1'(mrb)) begin
                failures++;
                $display("FAIL zero_tail got d=%h v=%b bank=%b exp d=0000 v=%b bank=%0d",
                         disp_rddata, disp_valid, render_bank, exp_dv, mrb);
            end
        end
    endtask

    task automatic test_bypass();
        tick(1'b0, 1'b1, 10'd5, 16'h1234, 10'd5, 1'b0, 10'd0);
        checks++; if (rend_rddata !== 16'h1234) begin failures++; $display("FAIL bypass got=%h exp=1234", rend_rddata); end
        repeat (3) tick(1'b0, 1'b0, 10'd0, 16'h0, 10'd0, 1'b0, 10'd0);
        tick(1'b0, 1'b0, 10'd0, 16'h0, 10'd5, 1'b0, 10'd0);
        checks++; if (rend_rddata !== 16'h1234) begin failures++; $display("FAIL reread got=%h exp=1234", rend_rddata); end
    endtask

    task automatic test_out_of_range();
        tick(1'b0, 1'b1, 10'd700, 16'hFFFF, 10'd700, 1'b0, 10'd0);
        checks++; if (rend_rddata !== 16'h0) begin failures++; $display("FAIL oob_bypass got=%h exp=0000", rend_rddata); end
        tick(1'b0, 1'b0, 10'd0, 16'h0, 10'd700, 1'b0, 10'd0);
        checks++; if (rend_rddata !== 16'h0) begin failures++; $display("FAIL oob_read got=%h exp=0000", rend_rddata); end
        for (int i = 0; i < 640; i++) begin
            tick(1'b0, 1'b0, 10'd0, 16'h0, 10'(i), 1'b0, 10'd0);
            checks++;
            if (rend_rddata !== exp_rend) begin
                failures++; $display("FAIL oob_scan idx=%0d got=%h exp=%h", i, rend_rddata, exp_rend);
            end
        end
        tick(1'b0, 1'b0, 10'd0, 16'h0, 10'd0, 1'b1, 10'd800);
        for (int k = 2; k <= DLAT; k++) tick(1'b0, 1'b0, 10'd0, 16'h0, 10'd0, 1'b0, 10'd0);
        checks++;
        if (disp_valid !== 1'b1 || disp_rddata !== 16'h0) begin
            failures++; $display("FAIL disp_oob got d=%h v=%b exp d=0000 v=1", disp_rddata, disp_valid);
        end
    endtask

    task automatic test_swap_read();
        tick(1'b0, 1'b1, 10'd10, 16'hA0C3, 10'd0, 1'b0, 10'd0);
        tick(1'b1, 1'b0, 10'd0, 16'h0, 10'd0, 1'b0, 10'd0);
        tick(1'b0, 1'b0, 10'd0, 16'h0, 10'd0, 1'b1, 10'd10);
        for (int k = 1; k <= DLAT; k++) begin
            if (k > 1) tick(1'b0, 1'b0, 10'd0, 16'h0, 10'd0, 1'b0, 10'd0);
            checks++;
            if (disp_valid !== (k == DLAT)) begin
                failures++; $display("FAIL swap_lat k=%0d got v=%b exp v=%b", k, disp_valid, (k == DLAT));
            end
        end
        checks++; if (disp_rddata !== 16'hA0C3) begin failures++; $display("FAIL swap_data got=%h exp=a0c3", disp_rddata); end
        tick(1'b0, 1'b0, 10'd0, 16'h0, 10'd0, 1'b0, 10'd0);
        checks++;
        if (disp_valid !== 1'b0 || disp_rddata !== 16'hA0C3) begin
            failures++; $display("FAIL hold got d=%h v=%b exp d=a0c3 v=0", disp_rddata, disp_valid);
        end
        tick(1'b0, 1'b0, 10'd0, 16'h0, 10'd0, 1'b1, 10'd10);
        for (int k = 2; k <= DLAT; k++) tick(1'b0, 1'b0, 10'd0, 16'h0, 10'd0, 1'b0, 10'd0);
        checks++;
        if (disp_valid !== 1'b1 || disp_rddata !== 16'h0) begin
            failures++; $display("FAIL cleared got d=%h v=%b exp d=0000 v=1", disp_rddata, disp_valid);
        end
    endtask

    task automatic test_read_at_swap();
        tick(1'b0, 1'b1, 10'd10, 16'h5A5A, 10'd0, 1'b0, 10'd0);
        tick(1'b1, 1'b0, 10'd0, 16'h0, 10'd0, 1'b0, 10'd0);
        tick(1'b0, 1'b1, 10'd10, 16'h0F0F, 10'd0, 1'b0, 10'd0);
        tick(1'b1, 1'b0, 10'd0, 16'h0, 10'd0, 1'b1, 10'd10);
        checks++; if (render_bank !== 1'(mrb)) begin failures++; $display("FAIL swap_bank got=%b exp=%0d", render_bank, mrb); end
        // Renderer reads the just-demoted bank while its clear is still in flight.
        tick(1'b0, 1'b0, 10'd0, 16'h0, 10'd10, 1'b0, 10'd0);
        checks++; if (rend_rddata !== 16'h0) begin failures++; $display("FAIL old_bank_clear got=%h exp=0000", rend_rddata); end
        checks++;
        if (disp_valid !== exp_dv || disp_rddata !== exp_dd || exp_dd !== 16'h5A5A) begin
            failures++; $display("FAIL swap_old_data got d=%h v=%b exp d=5a5a v=%b", disp_rddata, disp_valid, exp_dv);
        end
        tick(1'b0, 1'b0, 10'd0, 16'h0, 10'd10, 1'b1, 10'd10);
        for (int k = 2; k <= DLAT; k++) tick(1'b0, 1'b0, 10'd0, 16'h0, 10'd10, 1'b0, 10'd0);
        checks++;
        if (disp_valid !== 1'b1 || disp_rddata !== 16'h0F0F) begin
            failures++; $display("FAIL new_disp_intact got d=%h v=%b exp d=0f0f v=1", disp_rddata, disp_valid);
        end
    endtask

    task automatic test_random();
        logic [9:0] didx, prev;
        prev = 10'd1023;
        for (int n = 0; n < 600; n++) begin
            do didx = 10'($urandom_range(0, 699)); while (didx == prev);
            prev = didx;
            tick(($urandom_range(0, 19) == 0), 1'($urandom), 10'($urandom_range(0, 699)), 16'($urandom),
                 10'($urandom_range(0, 699)), 1'($urandom), didx);
            checks++;
            if (rend_rddata !== exp_rend || disp_valid !== exp_dv || disp_rddata !== exp_dd || render_bank !== 1'(mrb)) begin
                failures++;
                $display("FAIL random n=%0d got r=%h d=%h v=%b b=%b exp r=%h d=%h v=%b b=%0d",
                         n, rend_rddata, disp_rddata, disp_valid, render_bank, exp_rend, exp_dd, exp_dv, mrb);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int i = 0; i < 30; i++)
            tick(1'b0, 1'b1, 10'($urandom_range(0, 639)), 16'($urandom) | 16'h1, 10'd0, 1'b0, 10'd0);
        tick(1'b1, 1'b0, 10'd0, 16'h0, 10'd0, 1'b0, 10'd0);
        for (int i = 0; i < 30; i++)
            tick(1'b0, 1'b1, 10'($urandom_range(0, 639)), 16'($urandom) | 16'h1, 10'd0, 1'b1, 10'(i));
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b0 || render_bank !== 1'b0 || disp_valid !== 1'b0 || rend_rddata !== 16'h0 || disp_rddata !== 16'h0) begin
            failures++;
            $display("FAIL midreset got rdy=%b b=%b v=%b r=%h d=%h exp all 0", ready, render_bank, disp_valid, rend_rddata, disp_rddata);
        end
        drive_idle();
        rst_n = 1'b1;
        n = 0;
        while (n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (ready) break;
        end
        checks++; if (n !== 640) begin failures++; $display("FAIL reinit_len got=%0d exp=640", n); end
        model_reset();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 640; i++) begin
                tick(1'b0, 1'b0, 10'd0, 16'h0, 10'(i), 1'b1, 10'(i));
                checks++;
                if (disp_valid !== exp_dv || disp_rddata !== 16'h0 || rend_rddata !== 16'h0) begin
                    failures++;
                    $display("FAIL reinit_scan idx=%0d got d=%h v=%b r=%h exp d=0000 v=%b r=0000",
                             i, disp_rddata, disp_valid, rend_rddata, exp_dv);
                end
            end
            tick(1'b1, 1'b0, 10'd0, 16'h0, 10'd0, 1'b0, 10'd0);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_all_zero();
        test_bypass();
        test_out_of_range();
        test_swap_read();
        test_read_at_swap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
